// File: rtl/uart_tx.sv
// UART transmitter: start/8 data (LSB first)/optional even-sum parity/stop,
// OVS clock cycles per bit, one-entry holding buffer, sticky TI flag and
// one-cycle overflow pulse on dropped writes.
module uart_tx #(
    parameter int unsigned OVS       = 16,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       tx_int_clr,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_ready,
    output logic       tx_int,
    output logic       tx_ovf
);

    localparam int unsigned CW = $clog2(OVS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_par, w_par_n;
    logic [7:0]    r_buf, w_buf_n;
    logic          r_buf_full, w_buf_full_n;
    logic          r_txd, w_txd_n;
    logic          r_int, w_int_n;
    logic          r_ovf, w_ovf_n;

    logic w_tick;
    logic w_stop_end;
    logic w_load_buf;
    logic w_load_new;

    assign w_tick     = (r_cnt == CW'(OVS - 1));
    assign w_stop_end = (r_state == S_STOP) && w_tick;
    // Buffered byte has priority for the shifter; a fresh write goes straight
    // into the shifter only when nothing is waiting in the buffer.
    assign w_load_buf = w_stop_end && r_buf_full;
    assign w_load_new = tx_start && ((r_state == S_IDLE) || (w_stop_end && !r_buf_full));

    // State register and all datapath registers, async reset to idle line.
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_txd      <= 1'b1;
            r_int      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_shift    <= w_shift_n;
            r_par      <= w_par_n;
            r_buf      <= w_buf_n;
            r_buf_full <= w_buf_full_n;
            r_txd      <= w_txd_n;
            r_int      <= w_int_n;
            r_ovf      <= w_ovf_n;
        end
    end

    // Next-state, bit sequencing, buffer handling and flag logic.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
        w_bit_n      = r_bit;
        w_shift_n    = r_shift;
        w_par_n      = r_par;
        w_buf_n      = r_buf;
        w_buf_full_n = r_buf_full;
        w_txd_n      = r_txd;
        w_int_n      = r_int;
        w_ovf_n      = 1'b0;

        case (r_state)
            S_START: begin
                if (w_tick) begin
                    w_state_n = S_DATA;
                    w_bit_n   = '0;
                    w_txd_n   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        if (PARITY_EN) begin
                            w_state_n = S_PARITY;
                            w_txd_n   = r_par;
                        end else begin
                            w_state_n = S_STOP;
                            w_txd_n   = 1'b1;
                        end
                    end else begin
                        w_bit_n   = r_bit + 3'd1;
                        w_shift_n = r_shift >> 1;
                        w_txd_n   = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_n = S_STOP;
                    w_txd_n   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_n = S_IDLE;
                    w_txd_n   = 1'b1;
                end
            end
            default: ;
        endcase

        // Loads override the STOP->IDLE exit so back-to-back frames have no gap.
        if (w_load_buf) begin
            w_state_n    = S_START;
            w_shift_n    = r_buf;
            w_par_n      = ^r_buf;
            w_txd_n      = 1'b0;
            w_buf_full_n = 1'b0;
        end else if (w_load_new) begin
            w_state_n = S_START;
            w_shift_n = tx_data;
            w_par_n   = ^tx_data;
            w_txd_n   = 1'b0;
        end

        if (tx_start && !w_load_new) begin
            if (!r_buf_full || w_load_buf) begin
                w_buf_n      = tx_data;
                w_buf_full_n = 1'b1;
            end else begin
                w_ovf_n = 1'b1;
            end
        end

        if (w_stop_end) begin
            w_int_n = 1'b1;
        end else if (tx_int_clr) begin
            w_int_n = 1'b0;
        end
    end

    assign txd      = r_txd;
    assign tx_busy  = (r_state != S_IDLE) || r_buf_full;
    assign tx_ready = !r_buf_full;
    assign tx_int   = r_int;
    assign tx_ovf   = r_ovf;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a bit-level scoreboard on txd.
module tb_uart_tx;

    logic       clk_uart = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_int_clr = 1'b0;
    logic       txd, tx_busy, tx_ready, tx_int, tx_ovf;

    logic [7:0] tx_data2 = '0;
    logic       tx_start2 = 1'b0;
    logic       txd2, tx_busy2, tx_ready2, tx_int2, tx_ovf2;

    int unsigned total = 0;
    int unsigned bad = 0;
    int          cyc = 0;
    int          nxt = -1;
    logic        q1[$];
    logic        q2[$];

    uart_tx #(.OVS(16), .PARITY_EN(1'b1)) dut (
        .clk_uart(clk_uart), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_int_clr(tx_int_clr), .txd(txd), .tx_busy(tx_busy), .tx_ready(tx_ready),
        .tx_int(tx_int), .tx_ovf(tx_ovf)
    );

    uart_tx #(.OVS(16), .PARITY_EN(1'b0)) dut_np (
        .clk_uart(clk_uart), .rst(rst), .tx_data(tx_data2), .tx_start(tx_start2),
        .tx_int_clr(tx_int_clr), .txd(txd2), .tx_busy(tx_busy2), .tx_ready(tx_ready2),
        .tx_int(tx_int2), .tx_ovf(tx_ovf2)
    );

    always #5 clk_uart = ~clk_uart;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_frame(input bit np, input logic [7:0] d, input bit par_en);
        logic b;
        for (int i = 0; i < 11; i++) begin
            if (i == 0)               b = 1'b0;
            else if (i <= 8)          b = d[i-1];
            else if (i == 9 && par_en) b = ^d;
            else if (i == 9)          b = 1'b1;
            else                      continue;
            if (np) q2.push_back(b); else q1.push_back(b);
        end
        if (par_en) begin
            if (np) q2.push_back(1'b1); else q1.push_back(1'b1);
        end
    endtask

    // One clock; at each bit centre pop expected bits and compare.
    task automatic tick();
        logic e;
        @(posedge clk_uart);
        #1;
        cyc++;
        if (cyc == nxt && (q1.size() > 0 || q2.size() > 0)) begin
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("txd_bit", {7'b0, txd}, {7'b0, e});
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("txd_np_bit", {7'b0, txd2}, {7'b0, e});
            end
            nxt += 16;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Strobe from idle: the strobe edge becomes cycle 1.
    task automatic strobe_new(input logic [7:0] d, input bit both);
        cyc = 0;
        nxt = 9;
        tx_data = d;
        tx_start = 1'b1;
        if (both) begin
            tx_data2 = d;
            tx_start2 = 1'b1;
        end
        tick();
        tx_start = 1'b0;
        tx_start2 = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        tx_data = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        tick();
        tick();
        chk("rst_txd", {7'b0, txd}, 8'd1);
        chk("rst_busy", {7'b0, tx_busy}, 8'd0);
        chk("rst_ready", {7'b0, tx_ready}, 8'd1);
        chk("rst_int", {7'b0, tx_int}, 8'd0);
        chk("rst_ovf", {7'b0, tx_ovf}, 8'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_txd", {7'b0, txd}, 8'd1);

        // 0x55 frame, data changed after strobe, clr coincident with set
        push_frame(1'b0, 8'h55, 1'b1);
        strobe_new(8'h55, 1'b0);
        tx_data = 8'hAA;
        chk("f1_latency_txd", {7'b0, txd}, 8'd0);
        chk("f1_busy", {7'b0, tx_busy}, 8'd1);
        chk("f1_ready", {7'b0, tx_ready}, 8'd1);
        run_to(176);
        chk("f1_int_before", {7'b0, tx_int}, 8'd0);
        chk("f1_stop_txd", {7'b0, txd}, 8'd1);
        tx_int_clr = 1'b1;
        tick();
        chk("f1_int_set_wins", {7'b0, tx_int}, 8'd1);
        chk("f1_busy_end", {7'b0, tx_busy}, 8'd0);
        tick();
        tx_int_clr = 1'b0;
        chk("f1_int_cleared", {7'b0, tx_int}, 8'd0);
        chk("f1_q_empty", 8'(q1.size()), 8'd0);

        // 0x01 on both instances: parity 1 vs 10-bit frame
        tick();
        push_frame(1'b0, 8'h01, 1'b1);
        push_frame(1'b1, 8'h01, 1'b0);
        strobe_new(8'h01, 1'b1);
        run_to(160);
        chk("np_int_before", {7'b0, tx_int2}, 8'd0);
        chk("np_busy_before", {7'b0, tx_busy2}, 8'd1);
        tick();
        chk("np_int_161", {7'b0, tx_int2}, 8'd1);
        chk("np_busy_161", {7'b0, tx_busy2}, 8'd0);
        run_to(177);
        chk("f2_int_177", {7'b0, tx_int}, 8'd1);
        chk("f2_q_empty", 8'(q1.size()), 8'd0);
        chk("np_q_empty", 8'(q2.size()), 8'd0);
        tx_int_clr = 1'b1;
        tick();
        tx_int_clr = 1'b0;
        chk("f2_int_clr", {7'b0, tx_int}, 8'd0);

        // Back-to-back via holding buffer, third write dropped
        tick();
        push_frame(1'b0, 8'hA5, 1'b1);
        strobe_new(8'hA5, 1'b0);
        tx_data = 8'h11;
        run_to(19);
        push_frame(1'b0, 8'h3C, 1'b1);
        write(8'h3C);
        chk("buf_ready_low", {7'b0, tx_ready}, 8'd0);
        chk("buf_busy", {7'b0, tx_busy}, 8'd1);
        chk("buf_ovf_quiet", {7'b0, tx_ovf}, 8'd0);
        run_to(29);
        write(8'h77);
        chk("ovf_pulse", {7'b0, tx_ovf}, 8'd1);
        tick();
        chk("ovf_one_cycle", {7'b0, tx_ovf}, 8'd0);
        chk("ovf_ready", {7'b0, tx_ready}, 8'd0);
        run_to(176);
        chk("b2b_stop_txd", {7'b0, txd}, 8'd1);
        tick();
        chk("b2b_start_177", {7'b0, txd}, 8'd0);
        chk("b2b_ready_177", {7'b0, tx_ready}, 8'd1);
        chk("b2b_int_177", {7'b0, tx_int}, 8'd1);
        run_to(352);
        chk("b2b_busy_352", {7'b0, tx_busy}, 8'd1);
        tick();
        chk("b2b_busy_353", {7'b0, tx_busy}, 8'd0);
        chk("b2b_txd_353", {7'b0, txd}, 8'd1);
        chk("b2b_q_empty", 8'(q1.size()), 8'd0);

        // Reset during data bit 3 (tx_int still set from previous frames)
        tick();
        push_frame(1'b0, 8'h00, 1'b1);
        strobe_new(8'h00, 1'b0);
        run_to(70);
        chk("mid_txd_low", {7'b0, txd}, 8'd0);
        rst = 1'b1;
        #1;
        chk("arst_txd", {7'b0, txd}, 8'd1);
        chk("arst_busy", {7'b0, tx_busy}, 8'd0);
        chk("arst_ready", {7'b0, tx_ready}, 8'd1);
        chk("arst_int", {7'b0, tx_int}, 8'd0);
        chk("arst_ovf", {7'b0, tx_ovf}, 8'd0);
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_idle_txd", {7'b0, txd}, 8'd1);
        chk("post_rst_idle_busy", {7'b0, tx_busy}, 8'd0);
        push_frame(1'b0, 8'hFF, 1'b1);
        strobe_new(8'hFF, 1'b0);
        run_to(176);
        chk("ff_int_before", {7'b0, tx_int}, 8'd0);
        tick();
        chk("ff_int_177", {7'b0, tx_int}, 8'd1);
        chk("ff_q_empty", 8'(q1.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 OVS, default 16, SHALL set clk_uart cycles per bit (16x oversampling, 9600 baud); legal range 2..16.
REQ-002 PARITY_EN, default 1, SHALL insert the parity bit when 1 and omit it when 0.
REQ-003 clk_uart  input  1  SHALL be the single clock, at 16x baud; all logic on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 tx_data  input  8  SHALL be the byte to send, sampled only on an accepted tx_start.
REQ-006 tx_start  input  1  SHALL be a single-cycle write strobe (SBUF write).
REQ-007 tx_int_clr  input  1  SHALL be a software clear of tx_int.
REQ-008 txd  output  1  SHALL be the serial line, idle high.
REQ-009 tx_busy  output  1  SHALL be high while a frame is in progress or the holding buffer is full.
REQ-010 tx_ready  output  1  SHALL be high when the holding buffer is empty.
REQ-011 tx_int  output  1  SHALL be the sticky transmit-complete interrupt flag (TI).
REQ-012 tx_ovf  output  1  SHALL pulse for one cycle when a write is dropped.

Function
REQ-013 Frame SHALL be: start(0), data bits 0..7 LSB first, parity = ^data (only if PARITY_EN), stop(1). Each bit lasts exactly OVS cycles, so a full frame is 11*OVS cycles (176 at default).
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP. sample_cnt counts 0..OVS-1; bit_idx is 3 bits.
REQ-015 IDLE->START: tx_start=1 in IDLE SHALL capture tx_data into the shift register; txd SHALL go low on the next cycle (latency 1 cycle).
REQ-016 START->DATA, DATA->DATA (bit_idx+1), DATA->PARITY (or STOP if PARITY_EN=0), and PARITY->STOP SHALL occur only when sample_cnt=OVS-1.
REQ-017 At the end of STOP SHALL: set tx_int, then go to IDLE if the buffer is empty, or load the buffer into the shifter and enter START with no idle cycle between frames.
REQ-018 Holding buffer: one entry. tx_start while the shifter is busy and the buffer is empty SHALL capture tx_data into the buffer, with tx_ready=0 on the next cycle.
REQ-019 tx_start while the buffer is full SHALL be ignored; data is unchanged and tx_ovf pulses on the next cycle.
REQ-020 tx_start on the same cycle the buffer is moved into the shifter SHALL be accepted into the now-empty buffer.
REQ-021 tx_int SHALL stay at 1 until tx_int_clr. If tx_int_clr and a set occur on the same cycle, the set wins.
REQ-022 tx_int SHALL NOT block transmission; software handshakes via tx_int/tx_ready.
REQ-023 txd SHALL be driven from a register (no combinational glitches).
REQ-024 tx_data changing mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-025 rst=1 SHALL immediately force: txd=1, tx_busy=0, tx_ready=1, tx_int=0, tx_ovf=0, state IDLE, counters 0, buffer empty.
REQ-026 Reset asserted mid-frame SHALL abort the frame and return txd high asynchronously. The first frame after reset release SHALL start only on a new tx_start.

Verification
REQ-027 tx_data=0x55, tx_start pulse -> txd reads 0,1,0,1,0,1,0,1,0,P=0,1, each held 16 cycles. tx_int rises at cycle 177 after the strobe.
REQ-028 tx_data=0x01 -> parity bit=1. With PARITY_EN=0 -> 10-bit frame of 160 cycles, no parity bit.
REQ-029 Write 0xA5, then write 0x3C at cycle 20 -> tx_ready=0. Second start bit begins at cycle 177 with no idle gap. tx_busy falls at cycle 353.
REQ-030 Third write while the buffer is full -> tx_ovf one-cycle pulse, and only 0xA5 and 0x3C appear on txd.
REQ-031 tx_int_clr asserted on the exact cycle tx_int sets -> tx_int=1. A clear one cycle later -> tx_int=0.
REQ-032 rst pulse during DATA bit 3 -> txd=1 immediately, all outputs at reset values, and the next tx_start of 0xFF produces a correct frame.
